// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and helpers for the fully-connected layer control path
//
// Purpose: common word type, controller state encoding and the element-count
// clamp used by every layer_load_controller instance.
package fc_pkg;

  localparam int FC_SIZE     = 16;
  localparam int FC_LAYER_SZ = 2;

  typedef logic [FC_SIZE-1:0] fc_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  // Limit a requested element count to the number of neurons in the layer.
  function automatic fc_word_t clamp_count(input fc_word_t cnt, input fc_word_t lim);
    return (cnt > lim) ? lim : cnt;
  endfunction

endpackage

// File: rtl/layer_load_controller.sv
// rtl/layer_load_controller.sv - streams consecutive memory words into a layer load port
//
// Purpose: on start, reads count (clamped to LAYER_SZ) words from base_addr of a
// 1-cycle-latency memory and loads them into neuron indices 0..count-1, one per cycle.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start_i            transfer request, sampled only in IDLE
//   base_addr_i        first word address (captured with start_i)
//   count_i            element count (captured with start_i)
//   stall_i            suppresses read issue in the current RUN cycle
//   mem_rd_en_o        memory read strobe
//   mem_addr_o         memory read address
//   mem_rd_data_i      memory read data, valid the cycle after mem_rd_en_o
//   load_en_o          layer load strobe
//   load_address_o     neuron index being loaded
//   load_value_o       value being loaded (pass-through of mem_rd_data_i)
//   busy_o             transfer in progress
//   done_o             one-cycle completion pulse
module layer_load_controller
  import fc_pkg::*;
#(
  parameter int SIZE     = FC_SIZE,
  parameter int LAYER_SZ = FC_LAYER_SZ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [SIZE-1:0] base_addr_i,
  input  logic [SIZE-1:0] count_i,
  input  logic            stall_i,
  output logic            mem_rd_en_o,
  output logic [SIZE-1:0] mem_addr_o,
  input  logic [SIZE-1:0] mem_rd_data_i,
  output logic            load_en_o,
  output logic [SIZE-1:0] load_address_o,
  output logic [SIZE-1:0] load_value_o,
  output logic            busy_o,
  output logic            done_o
);

  ctrl_state_t     state_q, state_d;
  logic [SIZE-1:0] base_q, base_d;
  logic [SIZE-1:0] n_q, n_d;
  logic [SIZE-1:0] ri_q, ri_d;
  logic [SIZE-1:0] pi_q, pi_d;
  logic            pv_q, pv_d;

  logic [SIZE-1:0] count_clamped;
  logic            rd_fire;

  assign count_clamped = SIZE'(clamp_count(fc_word_t'(count_i), fc_word_t'(LAYER_SZ)));
  assign rd_fire       = (state_q == RUN) && !stall_i;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    n_d     = n_q;
    ri_d    = ri_q;
    pi_d    = pi_q;
    // A pending load only survives one cycle; it is re-armed by each issued read.
    pv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_clamped != '0) begin
            base_d  = base_addr_i;
            n_d     = count_clamped;
            ri_d    = '0;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (!stall_i) begin
          pv_d = 1'b1;
          pi_d = ri_q;
          ri_d = ri_q + SIZE'(1);
          if (ri_q == n_q - SIZE'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      n_q     <= '0;
      ri_q    <= '0;
      pi_q    <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      ri_q    <= ri_d;
      pi_q    <= pi_d;
      pv_q    <= pv_d;
    end
  end

  // Address wraps modulo 2^SIZE; held at zero when no read is issued.
  assign mem_rd_en_o    = rd_fire;
  assign mem_addr_o     = rd_fire ? (base_q + ri_q) : '0;
  assign load_en_o      = pv_q;
  assign load_address_o = pv_q ? pi_q : '0;
  assign load_value_o   = pv_q ? mem_rd_data_i : '0;
  assign busy_o         = (state_q == RUN) || (state_q == DRAIN);
  assign done_o         = (state_q == DONE);

endmodule
